// File: rtl/pipe_pkg.sv
// Shared pipeline types for the stage latches.
// latch_state_t : occupancy state of a skid latch; its encoding is the
//                 occupancy count itself (0, 1 or 2 entries held).
package pipe_pkg;

    typedef enum logic [1:0] {
        LS_EMPTY = 2'd0,
        LS_ONE   = 2'd1,
        LS_FULL  = 2'd2
    } latch_state_t;

    // Occupancy is reported as the raw state encoding.
    function automatic logic [1:0] occupancy_of(latch_state_t s);
        return 2'(s);
    endfunction

endpackage

// File: rtl/pipeline_latch_skid_if.sv
// Handshake bundle between a pipeline stage and its skid latch.
// Upstream side : flush, in_valid, in_data, in_ready
// Downstream    : out_valid, out_ready, out_data
// Monitoring    : occupancy (0..2), stall_count (saturating)
// master modport is the surrounding pipeline; slave is the latch.
interface pipeline_latch_skid_if #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 16
);
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [1:0]       occupancy;
    logic [CNT_W-1:0] stall_count;

    modport master (
        output flush, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, occupancy, stall_count
    );

    modport slave (
        input  flush, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, occupancy, stall_count
    );
endinterface

// File: rtl/pipeline_latch_skid_sat_counter.sv
// sat_counter: synchronous active-low cleared up-counter that sticks at
// all-ones instead of wrapping.
// Ports: CLK (rising edge), nRST (sync, active low), inc (count enable),
//        count (current value).
module sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         CLK,
    input  logic         nRST,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != '1)) begin
            count_d = count_q + W'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/pipeline_latch_skid.sv
// pipeline_latch_skid: valid/ready stage latch with a 2-entry skid buffer.
// in_ready depends only on registered state, cutting the combinational
// ready path from downstream to upstream stall logic.
// Ports: CLK, nRST (sync, active low), bus (slave side of
//        pipeline_latch_skid_if: flush, in_*, out_*, occupancy, stall_count).
// out_data is driven straight from the main (head) entry register.
module pipeline_latch_skid #(
    parameter int unsigned     WIDTH     = 32,
    parameter logic [WIDTH-1:0] FLUSH_VAL = '0,
    parameter int unsigned     CNT_W     = 16
) (
    input  logic                  CLK,
    input  logic                  nRST,
    pipeline_latch_skid_if.slave  bus
);
    import pipe_pkg::*;

    latch_state_t     state_q, state_d;
    logic [WIDTH-1:0] main_q, main_d;
    logic [WIDTH-1:0] skid_q, skid_d;
    logic             in_ready;
    logic             out_valid;
    logic             in_fire;
    logic             out_fire;
    logic [CNT_W-1:0] stall_count;

    always_comb begin
        state_d   = state_q;
        main_d    = main_q;
        skid_d    = skid_q;
        in_ready  = (state_q != LS_FULL);
        out_valid = (state_q != LS_EMPTY);
        in_fire   = bus.in_valid & in_ready;
        out_fire  = out_valid & bus.out_ready;

        if (bus.flush) begin
            // Any same-cycle input is dropped; a same-cycle output has
            // already been taken downstream, so nothing needs replaying.
            state_d = LS_EMPTY;
            main_d  = FLUSH_VAL;
            skid_d  = FLUSH_VAL;
        end else begin
            unique case (state_q)
                LS_EMPTY: begin
                    if (in_fire) begin
                        main_d  = bus.in_data;
                        state_d = LS_ONE;
                    end
                end
                LS_ONE: begin
                    if (in_fire && out_fire) begin
                        main_d = bus.in_data;
                    end else if (in_fire) begin
                        skid_d  = bus.in_data;
                        state_d = LS_FULL;
                    end else if (out_fire) begin
                        state_d = LS_EMPTY;
                    end
                end
                LS_FULL: begin
                    // in_ready is low here, so only the drain can happen.
                    if (out_fire) begin
                        main_d  = skid_q;
                        state_d = LS_ONE;
                    end
                end
                default: begin
                    state_d = LS_EMPTY;
                end
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state_q <= LS_EMPTY;
            main_q  <= FLUSH_VAL;
            skid_q  <= FLUSH_VAL;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

    sat_counter #(
        .W (CNT_W)
    ) u_stall_cnt (
        .CLK   (CLK),
        .nRST  (nRST),
        .inc   (out_valid & ~bus.out_ready),
        .count (stall_count)
    );

    assign bus.in_ready    = in_ready;
    assign bus.out_valid   = out_valid;
    assign bus.out_data    = main_q;
    assign bus.occupancy   = occupancy_of(state_q);
    assign bus.stall_count = stall_count;

endmodule

// File: tb/tb_pipeline_latch_skid.sv
module tb_pipeline_latch_skid;

    localparam int unsigned     WIDTH = 32;
    localparam int unsigned     CNT_W = 3;
    localparam logic [WIDTH-1:0] FV   = 32'hF0F0_0000;

    logic CLK;
    logic nRST;
    int   n_checks;
    int   n_fail;

    pipeline_latch_skid_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

    pipeline_latch_skid #(
        .WIDTH     (WIDTH),
        .FLUSH_VAL (FV),
        .CNT_W     (CNT_W)
    ) dut (
        .CLK  (CLK),
        .nRST (nRST),
        .bus  (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Advance one rising edge, then settle before sampling/driving.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        nRST         = 1'b0;
        bus.flush    = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data  = 32'hDEAD_BEEF;
        bus.out_ready = 1'b0;
        tick();
        tick();
        n_checks++;
        if (bus.out_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid);
        end
        n_checks++;
        if (bus.in_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready);
        end
        n_checks++;
        if (bus.occupancy !== 2'd0) begin
            n_fail++; $display("FAIL reset_occupancy: got %0d expected 0", bus.occupancy);
        end
        n_checks++;
        if (bus.stall_count !== 3'd0) begin
            n_fail++; $display("FAIL reset_stall: got %0d expected 0", bus.stall_count);
        end
        n_checks++;
        if (bus.out_data !== FV) begin
            n_fail++; $display("FAIL reset_out_data: got %h expected %h", bus.out_data, FV);
        end
        nRST         = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_data  = 'x;
        tick();
    endtask

    task automatic test_streaming();
        logic [WIDTH-1:0] vals [3];
        vals[0] = 32'h1; vals[1] = 32'h2; vals[2] = 32'h3;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = vals[i];
            tick();
            n_checks++;
            if (bus.out_valid !== 1'b1 || bus.out_data !== vals[i]) begin
                n_fail++;
                $display("FAIL stream_data[%0d]: got v=%b d=%h expected v=1 d=%h",
                         i, bus.out_valid, bus.out_data, vals[i]);
            end
            n_checks++;
            if (bus.occupancy !== 2'd1 || bus.in_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL stream_occ[%0d]: got occ=%0d rdy=%b expected occ=1 rdy=1",
                         i, bus.occupancy, bus.in_ready);
            end
        end
        bus.in_valid = 1'b0;
        bus.in_data  = 'x;
        tick();
        n_checks++;
        if (bus.occupancy !== 2'd0 || bus.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL stream_drain: got occ=%0d v=%b expected occ=0 v=0",
                     bus.occupancy, bus.out_valid);
        end
        n_checks++;
        if (bus.stall_count !== 3'd0) begin
            n_fail++; $display("FAIL stream_stall: got %0d expected 0", bus.stall_count);
        end
    endtask

    task automatic test_backpressure();
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_data   = 32'hA;
        tick();
        bus.in_data   = 32'hB;
        tick();
        bus.in_valid  = 1'b0;
        bus.in_data   = 'x;
        n_checks++;
        if (bus.occupancy !== 2'd2 || bus.in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_full: got occ=%0d rdy=%b expected occ=2 rdy=0",
                     bus.occupancy, bus.in_ready);
        end
        for (int i = 0; i < 2; i++) begin
            tick();
            n_checks++;
            if (bus.out_data !== 32'hA || bus.out_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL bp_hold[%0d]: got v=%b d=%h expected v=1 d=0000000a",
                         i, bus.out_valid, bus.out_data);
            end
        end
        n_checks++;
        if (bus.stall_count !== 3'd3) begin
            n_fail++; $display("FAIL bp_stall: got %0d expected 3", bus.stall_count);
        end
        bus.out_ready = 1'b1;
        tick();
        n_checks++;
        if (bus.out_data !== 32'hB || bus.occupancy !== 2'd1) begin
            n_fail++;
            $display("FAIL bp_second: got d=%h occ=%0d expected d=0000000b occ=1",
                     bus.out_data, bus.occupancy);
        end
        tick();
        n_checks++;
        if (bus.occupancy !== 2'd0 || bus.stall_count !== 3'd3) begin
            n_fail++;
            $display("FAIL bp_drain: got occ=%0d stall=%0d expected occ=0 stall=3",
                     bus.occupancy, bus.stall_count);
        end
    endtask

    task automatic test_flush_full();
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_data   = 32'hA;
        tick();
        bus.in_data   = 32'hB;
        tick();
        // FULL now; one stalled cycle added: 3 -> 4.
        n_checks++;
        if (bus.occupancy !== 2'd2 || bus.stall_count !== 3'd4) begin
            n_fail++;
            $display("FAIL flush_pre: got occ=%0d stall=%0d expected occ=2 stall=4",
                     bus.occupancy, bus.stall_count);
        end
        bus.flush     = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_data   = 32'hC;
        bus.out_ready = 1'b1;
        tick();
        bus.flush     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = 'x;
        n_checks++;
        if (bus.occupancy !== 2'd0 || bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_state: got occ=%0d v=%b rdy=%b expected occ=0 v=0 rdy=1",
                     bus.occupancy, bus.out_valid, bus.in_ready);
        end
        n_checks++;
        if (bus.out_data !== FV || bus.stall_count !== 3'd4) begin
            n_fail++;
            $display("FAIL flush_data: got d=%h stall=%0d expected d=%h stall=4",
                     bus.out_data, bus.stall_count, FV);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if (bus.out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL flush_no_c[%0d]: got v=%b d=%h expected v=0",
                         i, bus.out_valid, bus.out_data);
            end
        end
    endtask

    task automatic test_saturation();
        logic [CNT_W-1:0] exp_cnt;
        exp_cnt       = 3'd4;
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_data   = 32'h9;
        tick();
        bus.in_valid  = 1'b0;
        bus.in_data   = 'x;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (exp_cnt != 3'd7) exp_cnt = exp_cnt + 3'd1;
            n_checks++;
            if (bus.stall_count !== exp_cnt) begin
                n_fail++;
                $display("FAIL sat_step[%0d]: got %0d expected %0d", i, bus.stall_count, exp_cnt);
            end
        end
        n_checks++;
        if (bus.stall_count !== 3'd7 || bus.out_data !== 32'h9) begin
            n_fail++;
            $display("FAIL sat_final: got stall=%0d d=%h expected stall=7 d=00000009",
                     bus.stall_count, bus.out_data);
        end
    endtask

    task automatic test_reset_mid();
        nRST = 1'b0;
        tick();
        nRST          = 1'b1;
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_data   = 32'hA;
        tick();
        bus.in_data   = 32'hB;
        tick();
        bus.in_valid  = 1'b0;
        bus.in_data   = 'x;
        for (int i = 0; i < 4; i++) tick();
        n_checks++;
        if (bus.occupancy !== 2'd2 || bus.stall_count !== 3'd5) begin
            n_fail++;
            $display("FAIL mid_pre: got occ=%0d stall=%0d expected occ=2 stall=5",
                     bus.occupancy, bus.stall_count);
        end
        nRST         = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data  = 32'h77;
        tick();
        n_checks++;
        if (bus.occupancy !== 2'd0 || bus.stall_count !== 3'd0 ||
            bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset: got occ=%0d stall=%0d rdy=%b v=%b expected 0 0 1 0",
                     bus.occupancy, bus.stall_count, bus.in_ready, bus.out_valid);
        end
        nRST          = 1'b1;
        bus.out_ready = 1'b1;
        bus.in_data   = 32'h55;
        tick();
        bus.in_valid  = 1'b0;
        bus.in_data   = 'x;
        n_checks++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 32'h55) begin
            n_fail++;
            $display("FAIL mid_pass: got v=%b d=%h expected v=1 d=00000055",
                     bus.out_valid, bus.out_data);
        end
        tick();
        n_checks++;
        if (bus.occupancy !== 2'd0) begin
            n_fail++; $display("FAIL mid_drain: got occ=%0d expected 0", bus.occupancy);
        end
    endtask

    initial begin
        n_checks      = 0;
        n_fail        = 0;
        nRST          = 1'b0;
        bus.flush     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        #1;
        test_reset();
        test_streaming();
        test_backpressure();
        test_flush_full();
        test_saturation();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
